// File: rtl/power_seq_if.sv
// Signal bundle between the power sequencer and the rails it controls.
// The sequencer uses the master modport; the rail/supply side uses the slave modport.
interface power_seq_if #(
    parameter int N_CH = 4
);
    logic                    power_good;
    logic [N_CH-1:0]         ch_good;
    logic                    fault_clr;
    logic [N_CH-1:0]         enable;
    logic                    seq_done;
    logic                    fault;
    logic [$clog2(N_CH)-1:0] fault_ch;

    modport master (
        input  power_good, ch_good, fault_clr,
        output enable, seq_done, fault, fault_ch
    );

    modport slave (
        output power_good, ch_good, fault_clr,
        input  enable, seq_done, fault, fault_ch
    );
endinterface

// File: rtl/power_seq.sv
// Power rail sequencer: qualifies the main supply, ramps N_CH rails in order with a per-rail
// timeout and supervises them while on. Define POWER_SEQ_DOWN_SEQ_EN for ordered rail shutdown.
module power_seq #(
    parameter int N_CH           = 4,
    parameter int GOOD_CYCLES    = 30,
    parameter int STEP_CYCLES    = 10,
    parameter int TIMEOUT_CYCLES = 50
) (
    input  logic        clk,
    input  logic        resetb,
    power_seq_if.master bus
);
    localparam int MAX_GS  = (GOOD_CYCLES > STEP_CYCLES) ? GOOD_CYCLES : STEP_CYCLES;
    localparam int MAX_ALL = (MAX_GS > TIMEOUT_CYCLES) ? MAX_GS : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);
    localparam int IDX_W   = $clog2(N_CH);

    // The IDLE->QUAL edge already counts as the first good sample, hence GOOD_CYCLES-2.
    localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'((GOOD_CYCLES > 1) ? GOOD_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'((STEP_CYCLES > 0) ? STEP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_CH   = IDX_W'(N_CH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        QUAL  = 3'd1,
        RAMP  = 3'd2,
        ON    = 3'd3,
        DOWN  = 3'd4,
        FAULT = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  k_q, k_d;
    logic              settled_q, settled_d;
    logic [N_CH-1:0]   enable_q, enable_d;
    logic              seq_done_q, seq_done_d;
    logic              fault_q, fault_d;
    logic [IDX_W-1:0]  fault_ch_q, fault_ch_d;
    logic              start_ramp;
    logic              trip;
    logic [IDX_W-1:0]  trip_ch;
    logic [N_CH-1:0]   bad;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    // Rails whose good has been confirmed: every rail below k, plus k once it has reported good.
    function automatic logic [N_CH-1:0] good_mask(input logic [IDX_W-1:0] k, input logic settled);
        logic [N_CH-1:0] m;
        for (int i = 0; i < N_CH; i++)
            m[i] = (IDX_W'(i) < k) || ((IDX_W'(i) == k) && settled);
        return m;
    endfunction

    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_CH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_CH - 1; i >= 0; i--)
            if (v[i]) idx = IDX_W'(i);
        return idx;
    endfunction

`ifdef POWER_SEQ_DOWN_SEQ_EN
    function automatic logic [N_CH-1:0] clear_highest(input logic [N_CH-1:0] v);
        logic [N_CH-1:0] r;
        r = v;
        for (int i = 0; i < N_CH; i++)
            if (v[i]) begin
                r    = v;
                r[i] = 1'b0;
            end
        return r;
    endfunction
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        settled_d  = settled_q;
        enable_d   = enable_q;
        seq_done_d = seq_done_q;
        fault_d    = fault_q;
        fault_ch_d = fault_ch_q;
        start_ramp = 1'b0;
        trip       = 1'b0;
        trip_ch    = '0;
        bad        = enable_q & good_mask(k_q, settled_q) & ~bus.ch_good;

        case (state_q)
            IDLE: begin
                if (bus.power_good) begin
                    if (GOOD_CYCLES > 1) begin
                        state_d = QUAL;
                        cnt_d   = '0;
                    end else begin
                        start_ramp = 1'b1;
                    end
                end
            end
            QUAL: begin
                if (!bus.power_good) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == QUAL_LAST) begin
                    start_ramp = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            RAMP, ON: begin
                // Supply loss wins over any rail fault seen on the same edge.
                if (!bus.power_good) begin
                    state_d    = DOWN;
                    cnt_d      = '0;
                    seq_done_d = 1'b0;
`ifdef POWER_SEQ_DOWN_SEQ_EN
                    enable_d   = clear_highest(enable_q);
`else
                    enable_d   = '0;
`endif
                end else if (|bad) begin
                    trip    = 1'b1;
                    trip_ch = lowest_set(bad);
                end else if (state_q == RAMP) begin
                    if (!settled_q) begin
                        if (bus.ch_good[k_q]) begin
                            cnt_d     = '0;
                            settled_d = 1'b1;
                            if (k_q == LAST_CH) begin
                                state_d    = ON;
                                seq_done_d = 1'b1;
                            end
                        end else if (cnt_q == TMO_LAST) begin
                            trip    = 1'b1;
                            trip_ch = k_q;
                        end else begin
                            cnt_d = sat_inc(cnt_q);
                        end
                    end else if (cnt_q == STEP_LAST) begin
                        k_d                   = k_q + 1'b1;
                        enable_d[k_q + 1'b1]  = 1'b1;
                        settled_d             = 1'b0;
                        cnt_d                 = '0;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
            end
            DOWN: begin
`ifdef POWER_SEQ_DOWN_SEQ_EN
                if (enable_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == STEP_LAST) begin
                    enable_d = clear_highest(enable_q);
                    cnt_d    = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
`else
                state_d  = IDLE;
                cnt_d    = '0;
                enable_d = '0;
`endif
            end
            FAULT: begin
                if (bus.fault_clr && !bus.power_good) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    fault_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                cnt_d      = '0;
                enable_d   = '0;
                seq_done_d = 1'b0;
            end
        endcase

        if (start_ramp) begin
            state_d     = RAMP;
            cnt_d       = '0;
            k_d         = '0;
            settled_d   = 1'b0;
            enable_d[0] = 1'b1;
        end

        if (trip) begin
            state_d    = FAULT;
            cnt_d      = '0;
            enable_d   = '0;
            seq_done_d = 1'b0;
            fault_d    = 1'b1;
            fault_ch_d = trip_ch;
        end
    end

    always_ff @(posedge clk) begin
        if (resetb) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            k_q        <= '0;
            settled_q  <= 1'b0;
            enable_q   <= '0;
            seq_done_q <= 1'b0;
            fault_q    <= 1'b0;
            fault_ch_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            settled_q  <= settled_d;
            enable_q   <= enable_d;
            seq_done_q <= seq_done_d;
            fault_q    <= fault_d;
            fault_ch_q <= fault_ch_d;
        end
    end

    assign bus.enable   = enable_q;
    assign bus.seq_done = seq_done_q;
    assign bus.fault    = fault_q;
    assign bus.fault_ch = fault_ch_q;
endmodule

// File: tb/tb_power_seq.sv
// Self-checking bench for power_seq: randomized rail response times against an edge-time
// model of the sequencing rules, plus a second instance with N_CH=8, GOOD_CYCLES=5.
`timescale 1ns/1ps
module tb_power_seq;
    localparam int N_CH  = 4;
    localparam int GOOD  = 30;
    localparam int STEP  = 10;
    localparam int TMO   = 50;
    localparam int IDX_W = $clog2(N_CH);
    localparam int NEVER = 1000;
    localparam int FAR   = 100000;
`ifdef POWER_SEQ_DOWN_SEQ_EN
    localparam bit DOWN_SEQ = 1'b1;
`else
    localparam bit DOWN_SEQ = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetb;
    logic resetb8;

    power_seq_if #(.N_CH(N_CH)) bus ();
    power_seq_if #(.N_CH(8))    bus8 ();

    power_seq #(
        .N_CH(N_CH), .GOOD_CYCLES(GOOD), .STEP_CYCLES(STEP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .resetb(resetb), .bus(bus)
    );

    power_seq #(
        .N_CH(8), .GOOD_CYCLES(5), .STEP_CYCLES(10), .TIMEOUT_CYCLES(50)
    ) dut8 (
        .clk(clk), .resetb(resetb8), .bus(bus8)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.power_good = 1'b0;
        bus.ch_good    = '0;
        bus.fault_clr  = 1'b0;
        resetb         = 1'b1;
        tick();
        resetb         = 1'b0;
    endtask

    // Starts from IDLE with power_good rising on edge 1; rail k reports good d[k] edges after its
    // enable. Enable/seq_done/fault expectations come from absolute edge times.
    task automatic run_ramp(input int d [N_CH], input int extra);
        int en_t [N_CH];
        int fault_t, fault_k, on_t, t, t_end;
        bit alive;
        logic [N_CH-1:0] cg, exp_en;
        logic exp_done, exp_fault;
        fault_t = -1; fault_k = 0; on_t = -1; t = GOOD; alive = 1'b1;
        for (int k = 0; k < N_CH; k++) en_t[k] = FAR;
        for (int k = 0; k < N_CH; k++) begin
            if (alive) begin
                en_t[k] = t;
                if (d[k] > TMO) begin
                    fault_t = t + TMO;
                    fault_k = k;
                    alive   = 1'b0;
                end else if (k == N_CH - 1) begin
                    on_t = t + d[k];
                end else begin
                    t = t + d[k] + STEP;
                end
            end
        end
        t_end = ((on_t >= 0) ? on_t : fault_t) + extra;
        bus.power_good = 1'b1;
        for (int tt = 1; tt <= t_end; tt++) begin
            for (int k = 0; k < N_CH; k++) cg[k] = (tt >= en_t[k] + d[k]);
            bus.ch_good = cg;
            tick();
            exp_fault = (fault_t >= 0) && (tt >= fault_t);
            exp_done  = (on_t >= 0) && (tt >= on_t);
            for (int k = 0; k < N_CH; k++) exp_en[k] = (tt >= en_t[k]) && !exp_fault;
            checks++;
            if ({bus.enable, bus.seq_done, bus.fault} !== {exp_en, exp_done, exp_fault})
                $display("FAIL ramp t=%0d: enable/done/fault got %b/%b/%b expected %b/%b/%b",
                         tt, bus.enable, bus.seq_done, bus.fault, exp_en, exp_done, exp_fault);
            else passed++;
            if (tt == fault_t) begin
                checks++;
                if (bus.fault_ch !== IDX_W'(fault_k))
                    $display("FAIL ramp_fault_ch t=%0d: got %0d expected %0d", tt, bus.fault_ch, fault_k);
                else passed++;
            end
        end
    endtask

    task automatic test_reset();
        resetb         = 1'b1;
        bus.power_good = 1'b1;
        bus.ch_good    = '1;
        bus.fault_clr  = 1'b1;
        tick();
        checks++;
        if ({bus.enable, bus.seq_done, bus.fault, bus.fault_ch} !== '0)
            $display("FAIL reset_state: got en=%b done=%b fault=%b ch=%0d expected all 0",
                     bus.enable, bus.seq_done, bus.fault, bus.fault_ch);
        else passed++;
        tick();
        checks++;
        if (bus.enable !== '0) $display("FAIL reset_hold: enable got %b expected 0", bus.enable);
        else passed++;
        do_reset();
        tick();
        checks++;
        if (bus.enable !== '0) $display("FAIL reset_idle: enable got %b expected 0", bus.enable);
        else passed++;
    endtask

    // power_good runs shorter than GOOD never enable; the enable appears on the GOOD-th sample of a run.
    task automatic test_qual();
        int runs [8];
        int r;
        bit fired, pg;
        logic [N_CH-1:0] exp_en;
        do_reset();
        runs[0] = GOOD - 1;
        for (int i = 1; i < 7; i++) runs[i] = $urandom_range(1, GOOD - 1);
        runs[7] = GOOD;
        r = 0; fired = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < runs[i] + ((i == 7) ? 0 : $urandom_range(1, 3)); j++) begin
                pg = (j < runs[i]);
                bus.power_good = pg;
                tick();
                r = pg ? r + 1 : 0;
                if (r >= GOOD) fired = 1'b1;
                exp_en = '0;
                exp_en[0] = fired;
                checks++;
                if (bus.enable !== exp_en)
                    $display("FAIL qual run=%0d len=%0d: enable got %b expected %b", i, r, bus.enable, exp_en);
                else passed++;
            end
        end
        do_reset();
    endtask

    task automatic test_ramp();
        int d [N_CH];
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int k = 0; k < N_CH; k++) d[k] = $urandom_range(1, TMO);
            if (it == 0) for (int k = 0; k < N_CH; k++) d[k] = 2;
            if (it == 1) d[it] = TMO;
            if (it == 2) d[it] = 1;
            run_ramp(d, 4);
        end
        do_reset();
    endtask

    task automatic test_down();
        int d [N_CH];
        int z, last, c;
        logic [N_CH-1:0] exp_en;
        do_reset();
        for (int k = 0; k < N_CH; k++) d[k] = $urandom_range(1, TMO);
        run_ramp(d, 2);
        z    = DOWN_SEQ ? (N_CH - 1) * STEP : 0;
        last = z + 1 + GOOD;
        for (int m = 0; m <= last; m++) begin
            bus.power_good = (m != 0);
            bus.ch_good    = '0;
            tick();
            c = DOWN_SEQ ? (m / STEP + 1) : N_CH;
            exp_en = '0;
            for (int k = 0; k < N_CH; k++) exp_en[k] = (k < N_CH - c);
            if (m >= last) exp_en[0] = 1'b1;
            checks++;
            if ({bus.enable, bus.seq_done, bus.fault} !== {exp_en, 1'b0, 1'b0})
                $display("FAIL down m=%0d: enable/done/fault got %b/%b/%b expected %b/0/0",
                         m, bus.enable, bus.seq_done, bus.fault, exp_en);
            else passed++;
        end
        do_reset();
    endtask

    task automatic test_timeout();
        int d [N_CH];
        do_reset();
        d[0] = $urandom_range(1, TMO);
        d[1] = $urandom_range(1, TMO);
        d[2] = NEVER;
        d[3] = 1;
        run_ramp(d, 3);
        bus.fault_clr = 1'b1;
        tick();
        bus.fault_clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({bus.fault, bus.fault_ch, bus.enable} !== {1'b1, IDX_W'(2), {N_CH{1'b0}}})
                $display("FAIL clr_ignored i=%0d: fault=%b ch=%0d en=%b expected 1/2/0",
                         i, bus.fault, bus.fault_ch, bus.enable);
            else passed++;
            tick();
        end
        bus.power_good = 1'b0;
        tick();
        checks++;
        if (bus.fault !== 1'b1) $display("FAIL fault_held: got %b expected 1", bus.fault);
        else passed++;
        bus.fault_clr = 1'b1;
        tick();
        bus.fault_clr = 1'b0;
        bus.ch_good   = '0;
        checks++;
        if ({bus.fault, bus.enable, bus.seq_done} !== '0)
            $display("FAIL fault_clr: fault=%b en=%b done=%b expected 0", bus.fault, bus.enable, bus.seq_done);
        else passed++;
        for (int k = 0; k < N_CH; k++) d[k] = $urandom_range(1, TMO);
        run_ramp(d, 1);
        do_reset();
    endtask

    task automatic test_ch_drop();
        int d [N_CH];
        int j, j2;
        logic [N_CH-1:0] cg;
        for (int it = 0; it < 3; it++) begin
            do_reset();
            for (int k = 0; k < N_CH; k++) d[k] = $urandom_range(1, TMO);
            run_ramp(d, 2);
            j  = (it == 0) ? 1 : $urandom_range(0, N_CH - 1);
            cg = '1;
            cg[j] = 1'b0;
            if (it == 2 && j < N_CH - 1) begin
                j2 = $urandom_range(j + 1, N_CH - 1);
                cg[j2] = 1'b0;
            end
            bus.ch_good = cg;
            tick();
            checks++;
            if ({bus.enable, bus.seq_done, bus.fault, bus.fault_ch} !== {{N_CH{1'b0}}, 1'b0, 1'b1, IDX_W'(j)})
                $display("FAIL ch_drop it=%0d: en=%b done=%b fault=%b ch=%0d expected 0/0/1/%0d",
                         it, bus.enable, bus.seq_done, bus.fault, bus.fault_ch, j);
            else passed++;
            resetb = 1'b1;
            tick();
            resetb = 1'b0;
            checks++;
            if ({bus.enable, bus.seq_done, bus.fault, bus.fault_ch} !== '0)
                $display("FAIL reset_after_fault it=%0d: en=%b fault=%b ch=%0d expected 0",
                         it, bus.enable, bus.fault, bus.fault_ch);
            else passed++;
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        int tmid;
        logic [N_CH-1:0] exp_en;
        do_reset();
        bus.power_good = 1'b1;
        bus.ch_good    = '1;
        tmid = GOOD + STEP + 5;
        for (int tt = 1; tt <= tmid; tt++) tick();
        exp_en = '0;
        for (int k = 0; k < N_CH; k++) exp_en[k] = (GOOD + k * (1 + STEP) <= tmid);
        checks++;
        if (bus.enable !== exp_en) $display("FAIL mid_ramp: enable got %b expected %b", bus.enable, exp_en);
        else passed++;
        resetb = 1'b1;
        tick();
        resetb = 1'b0;
        checks++;
        if ({bus.enable, bus.seq_done, bus.fault, bus.fault_ch} !== '0)
            $display("FAIL reset_mid: en=%b done=%b fault=%b ch=%0d expected 0",
                     bus.enable, bus.seq_done, bus.fault, bus.fault_ch);
        else passed++;
        tick();
        checks++;
        if (bus.enable !== '0) $display("FAIL reset_mid_restart: enable got %b expected 0", bus.enable);
        else passed++;
        do_reset();
    endtask

    task automatic test_small_cfg();
        int pre, r;
        bit pg, fired;
        logic [7:0] exp_en;
        for (int it = 0; it < 2; it++) begin
            resetb8 = 1'b1;
            bus8.power_good = 1'b0;
            bus8.ch_good    = '0;
            bus8.fault_clr  = 1'b0;
            tick();
            resetb8 = 1'b0;
            pre = (it == 0) ? 3 : $urandom_range(1, 4);
            r = 0; fired = 1'b0;
            for (int tt = 0; tt < pre + 1 + 8; tt++) begin
                pg = (tt != pre);
                bus8.power_good = pg;
                tick();
                r = pg ? r + 1 : 0;
                if (r >= 5) fired = 1'b1;
                exp_en = {7'b0, fired};
                checks++;
                if (bus8.enable !== exp_en)
                    $display("FAIL small_cfg it=%0d tt=%0d: enable got %b expected %b", it, tt, bus8.enable, exp_en);
                else passed++;
            end
        end
        resetb8 = 1'b1;
    endtask

    initial begin
        resetb8         = 1'b1;
        bus8.power_good = 1'b0;
        bus8.ch_good    = '0;
        bus8.fault_clr  = 1'b0;
        test_reset();
        test_qual();
        test_ramp();
        test_down();
        test_timeout();
        test_ch_drop();
        test_reset_mid();
        test_small_cfg();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/power_seq.md
POWER_SEQ -- requirements
Module: power_seq

Interface
REQ-001 Parameter N_CH, default 4: number of sequenced rails, legal range 2..16.
REQ-002 Parameter GOOD_CYCLES, default 30: consecutive cycles power_good must be high before sequencing starts.
REQ-003 Parameter STEP_CYCLES, default 10: spacing between consecutive rail enable or disable events.
REQ-004 Parameter TIMEOUT_CYCLES, default 50: maximum cycles from enable[k] rise to ch_good[k] high.
REQ-005 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-006 resetb  input  1  reset, synchronous, active-high; port name kept for codebase consistency.
REQ-007 power_good  input  1  main supply good, synchronous to clk.
REQ-008 ch_good  input  N_CH  per-rail power-good feedback.
REQ-009 fault_clr  input  1  single-cycle pulse clearing a latched fault.
REQ-010 enable  output  N_CH  per-rail enables, registered.
REQ-011 seq_done  output  1  high while all rails are enabled and good.
REQ-012 fault  output  1  latched fault flag.
REQ-013 fault_ch  output  $clog2(N_CH)  index of the rail that caused the fault.

Function
REQ-014 FSM SHALL have states IDLE, QUAL, RAMP, ON, DOWN, FAULT; a single counter SHALL be cleared on every state transition and SHALL never wrap.
REQ-015 Counter width SHALL be $clog2(max(GOOD_CYCLES,STEP_CYCLES,TIMEOUT_CYCLES)+1); channel index width SHALL be $clog2(N_CH).
REQ-016 IDLE -> QUAL when power_good is sampled high.
REQ-017 QUAL: enable[0] SHALL rise on the edge where power_good has been sampled high GOOD_CYCLES consecutive times; state -> RAMP with k=0.
REQ-018 QUAL: power_good sampled low SHALL return to IDLE with the counter cleared; no enable SHALL assert.
REQ-019 RAMP: enable[k+1] SHALL rise STEP_CYCLES edges after ch_good[k] is first sampled high; enables already set SHALL stay set.
REQ-020 RAMP: ch_good[k] not sampled high within TIMEOUT_CYCLES edges after enable[k] rose -> FAULT, fault_ch=k.
REQ-021 ch_good[N_CH-1] sampled high -> ON; seq_done SHALL rise on that same edge.
REQ-022 RAMP/ON: any ch_good[j] with enable[j] set that is sampled low -> FAULT, fault_ch=j (lowest j if several).
REQ-023 RAMP/ON: power_good sampled low -> DOWN; seq_done SHALL fall on that edge; power_good low takes priority over a simultaneous ch_good fault.
REQ-024 FAULT: all enable bits SHALL clear on the entry edge; fault=1; seq_done=0; fault_ch held.
REQ-025 FAULT -> IDLE only on fault_clr high while power_good is low; fault_clr is ignored in other states and while power_good is high.
REQ-026 DOWN complete (all enables 0) -> IDLE; power_good returning high during DOWN SHALL NOT abort the shutdown.

Reset
REQ-027 resetb high at a rising edge SHALL force IDLE, enable=0, seq_done=0, fault=0, fault_ch=0, counter=0 on that edge.
REQ-028 resetb mid-sequence SHALL drop all enables on the same edge with no shutdown ordering; resetb SHALL take priority over all other inputs.

Configuration
REQ-029 Macro POWER_SEQ_DOWN_SEQ_EN defined: DOWN clears enable bits in reverse order, highest set bit first, one bit per STEP_CYCLES edges, starting on the DOWN entry edge.
REQ-030 POWER_SEQ_DOWN_SEQ_EN undefined: all enable bits SHALL clear on the DOWN entry edge, and DOWN SHALL exit to IDLE on the next edge.

Verification
REQ-031 Defaults; power_good high for 290 ns (29 cycles), then low -> enable stays 0; FSM returns to IDLE.
REQ-032 Defaults; power_good held high; each ch_good[k] returned 2 cycles after enable[k] -> enable[0] at +300 ns; enable[1..3] follow 10 cycles after each ch_good; seq_done=1.
REQ-033 Defaults, in ON; power_good low -> with macro, enable 1111->0111->0011->0001->0000 at 10-cycle spacing; without macro, 0000 on the next edge.
REQ-034 Defaults; ch_good[2] never returned -> fault=1, fault_ch=2, enable=0 exactly 50 cycles after enable[2] rose; fault_clr with power_good high is ignored; fault_clr with power_good low -> IDLE, fault=0.
REQ-035 Defaults, in ON; ch_good[1] dropped -> FAULT on the next edge with fault_ch=1; separately, resetb pulsed during RAMP -> all outputs 0 on the same edge.
REQ-036 N_CH=8, GOOD_CYCLES=5; power_good pulsed high 3 cycles, low 1 cycle, then high continuously -> enable[0] rises 5 cycles after the final rise.
